// File: rtl/lbist_pkg.sv
// ============================================================================
//  Module      : lbist_pkg
//  Description : Shared types and helpers for the logic-BIST sequencer.
//                Holds the one-hot state enum, the default parameter
//                constants, the counter-width helper, and the total
//                sequence-length function.
//  Ports       : none (package)
//  Config      : LBIST_MID_CHECK_EN (used by lbist_controller, not here)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lbist_pkg;

  localparam int unsigned DEF_N_PATTERNS = 1024;
  localparam int unsigned DEF_SCAN_LEN   = 64;
  localparam int unsigned DEF_SIG_WIDTH  = 32;

  // One-hot encoding, so every registered output is a single-bit decode.
  typedef enum logic [6:0] {
    ST_IDLE        = 7'b000_0001,
    ST_INIT        = 7'b000_0010,
    ST_SHIFT       = 7'b000_0100,
    ST_CAPTURE     = 7'b000_1000,
    ST_FINAL_SHIFT = 7'b001_0000,
    ST_COMPARE     = 7'b010_0000,
    ST_DONE        = 7'b100_0000
  } lbist_state_e;

  // Counter width for a count of v values, never narrower than one bit.
  function automatic int unsigned lbist_cnt_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Number of edges from the start-sampling edge until test_over_o is set.
  function automatic int unsigned lbist_cycles(input int unsigned n,
                                               input int unsigned l);
    return n * (l + 1) + l + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lbist_controller_if.sv
// ============================================================================
//  Module      : lbist_controller_if
//  Description : Test-control / LBIST-datapath bundle between the test pins
//                and the sequencer.
//  Ports       : master - test-control side: drives test_mode_i,
//                         normal_test_i, misr_sig_i; observes the results
//                slave  - lbist_controller: observes the requests and the
//                         MISR; drives bist_init_o, prpg_en_o, scan_en_o,
//                         misr_en_o, busy_o, test_over_o, go_nogo_o
//  Config      : none
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lbist_controller_if
  import lbist_pkg::*;
#(
  parameter int unsigned SIG_WIDTH = DEF_SIG_WIDTH
);

  logic                 test_mode_i;
  logic                 normal_test_i;
  logic [SIG_WIDTH-1:0] misr_sig_i;
  logic                 bist_init_o;
  logic                 prpg_en_o;
  logic                 scan_en_o;
  logic                 misr_en_o;
  logic                 busy_o;
  logic                 test_over_o;
  logic                 go_nogo_o;

  modport master (
    output test_mode_i, normal_test_i, misr_sig_i,
    input  bist_init_o, prpg_en_o, scan_en_o, misr_en_o,
           busy_o, test_over_o, go_nogo_o
  );

  modport slave (
    input  test_mode_i, normal_test_i, misr_sig_i,
    output bist_init_o, prpg_en_o, scan_en_o, misr_en_o,
           busy_o, test_over_o, go_nogo_o
  );

endinterface

`default_nettype wire

// File: rtl/lbist_pattern_counter.sv
// ============================================================================
//  Module      : lbist_pattern_counter
//  Description : Paired shift-cycle / pattern counters for the LBIST
//                sequencer, with terminal-count and midpoint flags.
//  Ports       : clk, rst_n  - clock, asynchronous active-low reset
//                clr_i       - clear both counters
//                sh_en_i     - advance shift counter (wraps to 0 at terminal)
//                pat_inc_i   - advance pattern counter (holds at terminal)
//                sh_last_o   - sh_cnt == SCAN_LEN-1
//                pat_last_o  - pat_cnt == N_PATTERNS-1
//                pat_zero_o  - pat_cnt == 0
//                pat_mid_o   - pat_cnt == N_PATTERNS/2
//  Config      : none
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbist_pattern_counter
  import lbist_pkg::*;
#(
  parameter int unsigned N_PATTERNS = DEF_N_PATTERNS,
  parameter int unsigned SCAN_LEN   = DEF_SCAN_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic sh_en_i,
  input  logic pat_inc_i,
  output logic sh_last_o,
  output logic pat_last_o,
  output logic pat_zero_o,
  output logic pat_mid_o
);

  localparam int unsigned PAT_W = lbist_cnt_width(N_PATTERNS);
  localparam int unsigned SH_W  = lbist_cnt_width(SCAN_LEN);

  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PATTERNS - 1);
  localparam logic [PAT_W-1:0] PAT_MID  = PAT_W'(N_PATTERNS / 2);
  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(SCAN_LEN - 1);

  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [SH_W-1:0]  sh_cnt_q,  sh_cnt_d;

  assign sh_last_o  = (sh_cnt_q == SH_LAST);
  assign pat_last_o = (pat_cnt_q == PAT_LAST);
  assign pat_zero_o = (pat_cnt_q == '0);
  assign pat_mid_o  = (pat_cnt_q == PAT_MID);

  always_comb begin
    sh_cnt_d  = sh_cnt_q;
    pat_cnt_d = pat_cnt_q;
    if (clr_i) begin
      sh_cnt_d  = '0;
      pat_cnt_d = '0;
    end else begin
      // Shift counter restarts at its terminal so the next shift burst
      // (pattern or final unload) begins from zero without a separate clear.
      if (sh_en_i) begin
        sh_cnt_d = sh_last_o ? '0 : sh_cnt_q + SH_W'(1);
      end
      // The last capture leaves the pattern count at N-1 rather than wrapping.
      if (pat_inc_i && !pat_last_o) begin
        pat_cnt_d = pat_cnt_q + PAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_cnt_q  <= '0;
      pat_cnt_q <= '0;
    end else begin
      sh_cnt_q  <= sh_cnt_d;
      pat_cnt_q <= pat_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lbist_controller.sv
// ============================================================================
//  Module      : lbist_controller
//  Description : Logic-BIST sequencer: seed PRPG, run N_PATTERNS
//                shift/capture patterns with MISR compaction, final unload,
//                then compare the MISR against GOLDEN_SIG and report.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                bus    - lbist_controller_if.slave (test requests, MISR in,
//                         PRPG/scan/MISR enables and status out)
//  Config      : LBIST_MID_CHECK_EN - adds a midpoint signature check
//                against GOLDEN_MID with early abort on mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lbist_controller
  import lbist_pkg::*;
#(
  parameter int unsigned          N_PATTERNS = DEF_N_PATTERNS,
  parameter int unsigned          SCAN_LEN   = DEF_SCAN_LEN,
  parameter int unsigned          SIG_WIDTH  = DEF_SIG_WIDTH,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = '0,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_MID = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  lbist_controller_if.slave bus
);

  lbist_state_e state_q, state_d;
  logic         pass_q, pass_d;

  logic bist_init_q, prpg_en_q, scan_en_q, misr_en_q;
  logic busy_q, test_over_q, go_nogo_q;
  logic bist_init_d, prpg_en_d, scan_en_d, misr_en_d;
  logic busy_d, test_over_d, go_nogo_d;

  logic w_start;
  logic w_busy_now;
  logic w_sh_last, w_pat_last, w_pat_zero, w_pat_mid;

  lbist_pattern_counter #(
    .N_PATTERNS (N_PATTERNS),
    .SCAN_LEN   (SCAN_LEN)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_q == ST_INIT),
    .sh_en_i    ((state_q == ST_SHIFT) || (state_q == ST_FINAL_SHIFT)),
    .pat_inc_i  (state_q == ST_CAPTURE),
    .sh_last_o  (w_sh_last),
    .pat_last_o (w_pat_last),
    .pat_zero_o (w_pat_zero),
    .pat_mid_o  (w_pat_mid)
  );

  assign w_start    = bus.normal_test_i && bus.test_mode_i;
  assign w_busy_now = (state_q == ST_INIT)    || (state_q == ST_SHIFT) ||
                      (state_q == ST_CAPTURE) || (state_q == ST_FINAL_SHIFT) ||
                      (state_q == ST_COMPARE);

`ifdef LBIST_MID_CHECK_EN
  logic mid_fail_q, mid_fail_d;
  logic w_mid_mismatch;
  assign w_mid_mismatch = w_pat_mid && (bus.misr_sig_i != GOLDEN_MID);
`else
  logic unused_mid;
  assign unused_mid = w_pat_mid ^ (^GOLDEN_MID);
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
`ifdef LBIST_MID_CHECK_EN
    mid_fail_d = mid_fail_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (w_start) state_d = ST_INIT;
      end
      ST_INIT: begin
        pass_d  = 1'b0;
`ifdef LBIST_MID_CHECK_EN
        mid_fail_d = 1'b0;
`endif
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_sh_last) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = w_pat_last ? ST_FINAL_SHIFT : ST_SHIFT;
`ifdef LBIST_MID_CHECK_EN
        if (w_mid_mismatch) begin
          mid_fail_d = 1'b1;
          pass_d     = 1'b0;
          state_d    = ST_DONE;
        end
`endif
      end
      ST_FINAL_SHIFT: begin
        if (w_sh_last) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
`ifdef LBIST_MID_CHECK_EN
        pass_d = (bus.misr_sig_i == GOLDEN_SIG) && !mid_fail_q;
`else
        pass_d = (bus.misr_sig_i == GOLDEN_SIG);
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (w_start) state_d = ST_INIT;
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing test mode mid-sequence abandons it silently; DONE is unaffected.
    if (w_busy_now && !bus.test_mode_i) state_d = ST_IDLE;
  end

  // Registered output decode from the next state.
  always_comb begin
    bist_init_d = (state_d == ST_INIT);
    prpg_en_d   = (state_d == ST_SHIFT);
    scan_en_d   = (state_d == ST_SHIFT) || (state_d == ST_FINAL_SHIFT);
    // The first pattern's shift unloads reset-state junk, so the MISR stays
    // off for it. Entering SHIFT from CAPTURE means at least one pattern was
    // captured; entering from INIT means the count is about to be zero.
    misr_en_d   = (state_d == ST_FINAL_SHIFT) ||
                  ((state_d == ST_SHIFT) &&
                   ((state_q == ST_CAPTURE) ||
                    ((state_q == ST_SHIFT) && !w_pat_zero)));
    busy_d      = (state_d == ST_INIT)    || (state_d == ST_SHIFT) ||
                  (state_d == ST_CAPTURE) || (state_d == ST_FINAL_SHIFT) ||
                  (state_d == ST_COMPARE);
    test_over_d = (state_d == ST_DONE);
    go_nogo_d   = (state_d == ST_DONE) && pass_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pass_q      <= 1'b0;
      bist_init_q <= 1'b0;
      prpg_en_q   <= 1'b0;
      scan_en_q   <= 1'b0;
      misr_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      test_over_q <= 1'b0;
      go_nogo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      bist_init_q <= bist_init_d;
      prpg_en_q   <= prpg_en_d;
      scan_en_q   <= scan_en_d;
      misr_en_q   <= misr_en_d;
      busy_q      <= busy_d;
      test_over_q <= test_over_d;
      go_nogo_q   <= go_nogo_d;
    end
  end

`ifdef LBIST_MID_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mid_fail_q <= 1'b0;
    else        mid_fail_q <= mid_fail_d;
  end
`endif

  assign bus.bist_init_o = bist_init_q;
  assign bus.prpg_en_o   = prpg_en_q;
  assign bus.scan_en_o   = scan_en_q;
  assign bus.misr_en_o   = misr_en_q;
  assign bus.busy_o      = busy_q;
  assign bus.test_over_o = test_over_q;
  assign bus.go_nogo_o   = go_nogo_q;

endmodule

`default_nettype wire

// File: tb/tb_lbist_controller.sv
// ============================================================================
//  Module      : tb_lbist_controller
//  Description : Self-checking bench for lbist_controller (N=4, L=8).
//                Expected outputs come from a cycle-indexed model built
//                from the sequence timing rules.
//  Config      : LBIST_MID_CHECK_EN (midpoint abort expectations)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lbist_controller;
  import lbist_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned L  = 8;
  localparam int unsigned SW = 32;
  localparam logic [31:0] GOLD     = 32'hDEADBEEF;
  localparam logic [31:0] GOLD_MID = 32'hDEADBEEF;
  localparam int T       = int'(lbist_cycles(N, L));
  localparam int PAT_END = int'(N * (L + 1));

  logic clk = 1'b0;
  logic rst_n;

  lbist_controller_if #(.SIG_WIDTH(SW)) bus ();

  lbist_controller #(
    .N_PATTERNS (N),
    .SCAN_LEN   (L),
    .SIG_WIDTH  (SW),
    .GOLDEN_SIG (GOLD),
    .GOLDEN_MID (GOLD_MID)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Output vector order: {bist_init, prpg_en, scan_en, misr_en, busy, test_over, go_nogo}
  function automatic logic [6:0] outs();
    return {bus.bist_init_o, bus.prpg_en_o, bus.scan_en_o, bus.misr_en_o,
            bus.busy_o, bus.test_over_o, bus.go_nogo_o};
  endfunction

  // Cycle (edge index after start) at which DONE is first visible.
  function automatic int done_time(input logic [31:0] sig);
    int dt;
    dt = T;
`ifdef LBIST_MID_CHECK_EN
    if (sig != GOLD_MID) dt = int'((N / 2 + 1) * (L + 1)) + 1;
`endif
    return dt;
  endfunction

  function automatic logic pass_of(input logic [31:0] sig);
    logic p;
    p = (sig == GOLD);
`ifdef LBIST_MID_CHECK_EN
    p = p && (sig == GOLD_MID);
`endif
    return p;
  endfunction

  // Expected outputs after edge t of an uninterrupted run with constant sig.
  function automatic logic [6:0] model(input int t, input logic [31:0] sig);
    int p;
    int o;
    if (t >= done_time(sig)) return {5'b00000, 1'b1, pass_of(sig)};
    if (t == 0) return 7'b1000100;
    if (t <= PAT_END) begin
      p = (t - 1) / int'(L + 1);
      o = (t - 1) % int'(L + 1);
      if (o < int'(L)) return {1'b0, 1'b1, 1'b1, (p > 0), 1'b1, 2'b00};
      return 7'b0000100;
    end
    if (t <= PAT_END + int'(L)) return 7'b0011100;
    return 7'b0000100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One start pulse then ncyc further edges, checked every cycle.
  task automatic run(input logic [31:0] sig, input int abort_at, input int extra_at,
                     input int ncyc, output int over_t, output int misr_cnt,
                     output logic go_end);
    logic [6:0] act;
    logic [6:0] ev;
    int dt;
    dt       = done_time(sig);
    over_t   = -1;
    misr_cnt = 0;
    act      = '0;
    bus.misr_sig_i    = sig;
    bus.test_mode_i   = 1'b1;
    bus.normal_test_i = 1'b1;
    step();
    bus.normal_test_i = 1'b0;
    for (int t = 0; t <= ncyc; t++) begin
      if (t > 0) begin
        bus.test_mode_i   = !(abort_at > 0 && t >= abort_at);
        bus.normal_test_i = (t == extra_at);
        step();
      end
      act = outs();
      if (abort_at > 0 && t >= abort_at && (abort_at - 1) < dt) ev = '0;
      else ev = model(t, sig);
      check($sformatf("outputs t=%0d", t), {25'd0, act}, {25'd0, ev});
      if (act[1] && over_t < 0) over_t = t;
      misr_cnt += int'(act[3]);
    end
    go_end = act[0];
    bus.test_mode_i   = 1'b1;
    bus.normal_test_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] sig;
    int          extra_at;
    logic        exp_go;
    int          exp_over;
    int          exp_misr;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int ot;
    int mc;
    logic g;
    logic [31:0] rs;
    int ab;
    int ex;
    int dt;

    tbl[0] = '{32'hDEADBEEF, 0, 1'b1, 46, 32};
    tbl[3] = '{32'hDEADBEEF, 5, 1'b1, 46, 32};
`ifdef LBIST_MID_CHECK_EN
    tbl[1] = '{32'hDEADBEEE, 0, 1'b0, 28, 16};
    tbl[2] = '{32'h00000000, 0, 1'b0, 28, 16};
`else
    tbl[1] = '{32'hDEADBEEE, 0, 1'b0, 46, 32};
    tbl[2] = '{32'h00000000, 0, 1'b0, 46, 32};
`endif

    // Reset state
    rst_n = 1'b0;
    bus.test_mode_i   = 1'b0;
    bus.normal_test_i = 1'b0;
    bus.misr_sig_i    = '0;
    #12;
    check("reset outputs", {25'd0, outs()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle after reset", {25'd0, outs()}, 32'd0);

    // Start with test mode low is not accepted
    bus.normal_test_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("start without test_mode %0d", i), {25'd0, outs()}, 32'd0);
    end
    bus.normal_test_i = 1'b0;

    // Table-driven full runs
    for (int i = 0; i < 4; i++) begin
      run(tbl[i].sig, 0, tbl[i].extra_at, T + 2, ot, mc, g);
      check($sformatf("vec%0d test_over edge", i), ot, tbl[i].exp_over);
      check($sformatf("vec%0d misr_en count", i), mc, tbl[i].exp_misr);
      check($sformatf("vec%0d go_nogo", i), {31'd0, g}, {31'd0, tbl[i].exp_go});
    end

    // test_mode dropped during pattern 2: silent return to IDLE
    run(GOLD, 13, 0, 60, ot, mc, g);
    check("abort test_over never", ot, -1);

    // test_mode dropped in DONE: results held
    run(GOLD, 0, 0, T + 1, ot, mc, g);
    bus.test_mode_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("done held %0d", i), {25'd0, outs()}, {25'd0, model(T, GOLD)});
    end
    bus.test_mode_i = 1'b1;

    // Start held high across DONE restarts immediately
    bus.misr_sig_i    = GOLD;
    bus.normal_test_i = 1'b1;
    step();
    check("held start t=0", {25'd0, outs()}, {25'd0, model(0, GOLD)});
    for (int t = 1; t <= T + 1; t++) begin
      step();
      check($sformatf("held start t=%0d", t), {25'd0, outs()},
            {25'd0, (t <= T) ? model(t, GOLD) : model(0, GOLD)});
    end
    bus.normal_test_i = 1'b0;
    for (int t = 1; t <= T; t++) begin
      step();
      check($sformatf("restart t=%0d", t), {25'd0, outs()}, {25'd0, model(t, GOLD)});
    end

    // Asynchronous reset in DONE, then a fresh run
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset in DONE", {25'd0, outs()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle after reset in DONE", {25'd0, outs()}, 32'd0);
    run(GOLD, 0, 0, T + 1, ot, mc, g);
    check("post-reset test_over edge", ot, T);
    check("post-reset go_nogo", {31'd0, g}, 32'd1);

    // Randomized runs
    for (int i = 0; i < 10; i++) begin
      rs = ($urandom_range(0, 1) == 0) ? GOLD : $urandom;
      dt = done_time(rs);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, T)) : 0;
      ex = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, dt)) : 0;
      run(rs, ab, ex, T + 2, ot, mc, g);
      if (ab > 0 && (ab - 1) < dt) begin
        check($sformatf("rand%0d test_over edge", i), ot, -1);
        check($sformatf("rand%0d go_nogo", i), {31'd0, g}, 32'd0);
      end else begin
        check($sformatf("rand%0d test_over edge", i), ot, dt);
        check($sformatf("rand%0d go_nogo", i), {31'd0, g}, {31'd0, pass_of(rs)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lbist_controller.md
# lbist_controller

Sequencer for the logic-BIST datapath wrapped around the RI5CY core. A `normal_test_i` start pulse launches the sequence: seed the PRPG, then run N scan-shift/capture patterns with MISR compaction, a final unload and a signature compare. It then reports `go_nogo_o` and `test_over_o`. It sits inside `riscv_wrapper` between the test-control pins and the PRPG, scan-chain and MISR enables.

## Interface
- `N_PATTERNS`, 1024: number of capture patterns; legal range 2..65535.
- `SCAN_LEN`, 64: shift cycles per pattern, equal to the longest compressed chain; legal range 1..4095.
- `SIG_WIDTH`, 32: MISR signature width.
- `GOLDEN_SIG`, `'0`: expected final signature, `SIG_WIDTH` bits.
- `GOLDEN_MID`, `'0`: expected midpoint signature; used only with `LBIST_MID_CHECK_EN`.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `test_mode_i`, in, 1: LBIST mode enable. Starts are accepted only while it is high.
- `normal_test_i`, in, 1: start request, level-sampled on posedge.
- `misr_sig_i`, in, `SIG_WIDTH`: current MISR contents.
- `bist_init_o`, out, 1: PRPG seed load and MISR clear.
- `prpg_en_o`, out, 1: PRPG advance.
- `scan_en_o`, out, 1: scan-enable to all chains.
- `misr_en_o`, out, 1: MISR compaction enable.
- `busy_o`, out, 1: sequence in progress.
- `test_over_o`, out, 1: sequence complete; results valid.
- `go_nogo_o`, out, 1: 1 = signature matched (pass).

## Operation
- States: IDLE, INIT, SHIFT, CAPTURE, FINAL_SHIFT, COMPARE, DONE.
- IDLE → INIT when `normal_test_i` && `test_mode_i`.
- DONE → INIT on a new start. Leaving DONE clears `test_over_o` and `go_nogo_o`.
- INIT (1 cycle):
  - `bist_init_o`=1.
  - Clear `pat_cnt` and `sh_cnt`.
  - Next state is SHIFT.
- SHIFT (`SCAN_LEN` cycles):
  - `scan_en_o`=1, `prpg_en_o`=1.
  - `misr_en_o`=1 except while `pat_cnt`==0; the first unload carries reset-state junk.
  - When `sh_cnt`==`SCAN_LEN`-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - All enables 0; functional clock capture.
  - Increment `pat_cnt`.
  - If `pat_cnt`==`N_PATTERNS`-1, go to FINAL_SHIFT; otherwise go to SHIFT.
- FINAL_SHIFT (`SCAN_LEN` cycles):
  - `scan_en_o`=1, `misr_en_o`=1, `prpg_en_o`=0.
- COMPARE (1 cycle): register `misr_sig_i`==`GOLDEN_SIG` into a pass flag.
- DONE:
  - `test_over_o`=1, `go_nogo_o`=pass flag.
  - Hold until a new start or reset.
- `busy_o`=1 in INIT through COMPARE.
- Counter widths: `$clog2(N_PATTERNS)` and `$clog2(SCAN_LEN)`, each minimum 1 bit. Counters never wrap mid-sequence; terminal compares are on count-1.
- Boundary rules:
  - Start while busy: ignored.
  - Start held high across DONE: restarts immediately; a level, not an edge.
  - `test_mode_i` falls during any busy state: next state IDLE, all outputs 0, no `test_over_o` pulse.
  - `test_mode_i` falls in DONE: results are held.
  - `rst_n` asserted at any time: IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- All outputs are registered (one-hot state decode). They change only at posedge.
- Let edge 0 be the edge that samples the start request, L=`SCAN_LEN`, N=`N_PATTERNS`:
  - INIT after edge 0.
  - SHIFT after edges 1..L.
  - CAPTURE after edge L+1.
  - Each pattern takes L+1 cycles.
  - FINAL_SHIFT after edges N(L+1)+1..N(L+1)+L.
  - COMPARE after edge N(L+1)+L+1.
  - DONE (`test_over_o`=1) after edge N(L+1)+L+2.
- `misr_sig_i` is sampled at the edge that leaves COMPARE. The MISR must be settled one cycle after the last `misr_en_o`.

## Configuration
- `LBIST_MID_CHECK_EN` defined:
  - At the CAPTURE where `pat_cnt`==N/2, compare `misr_sig_i` against `GOLDEN_MID` and store a `mid_fail` sticky bit.
  - If `mid_fail` is set, jump directly to DONE with `go_nogo_o`=0 (early abort).
  - The final `go_nogo_o` also requires `mid_fail`==0.
- Undefined: no midpoint compare; `GOLDEN_MID` is unused; the sequence always runs full length.

## Structure
- `lbist_pkg` holds:
  - The `lbist_state_e` enum.
  - Default parameter constants.
  - A `lbist_cycles(N,L)` function returning N(L+1)+L+2, shared with the bench.
- One sub-module, `lbist_pattern_counter`: paired `sh_cnt`/`pat_cnt` with clear, terminal-count flags and midpoint flag.
- The FSM and output decode stay in `lbist_controller`.

## Test plan
- N=4, L=8, `GOLDEN_SIG`=`32'hDEADBEEF`, `misr_sig_i` tied to `32'hDEADBEEF`, start pulse → `test_over_o` rises 46 edges after the start edge; `go_nogo_o`=1; `misr_en_o` count = 32 (3×8 + 8).
- Same configuration with `misr_sig_i`=`32'hDEADBEEE` → `test_over_o`=1, `go_nogo_o`=0.
- `test_mode_i` dropped during pattern 2 → IDLE next cycle; all outputs 0; `test_over_o` never asserts.
- Second start pulse during SHIFT → ignored; completion still at edge 46 of the first start.
- `rst_n` pulsed low in DONE → all outputs 0 asynchronously. A fresh start then completes normally.
- `LBIST_MID_CHECK_EN` defined, `misr_sig_i`≠`GOLDEN_MID` at the pattern-2 CAPTURE → DONE next cycle with `go_nogo_o`=0.
